// File: rtl/seg_scan_pkg.sv
// seg_scan shared constants: digit count, cathode table, blank code.
// Patterns are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int DIGITS = 8;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef logic [$clog2(DIGITS)-1:0] idx_t;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_if.sv
// seg_scan data/control bundle between host and display scanner.
// Signal names follow the display pin naming.
interface seg_scan_if;

  logic [31:0] value;
  logic        load;
  logic        enable;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic        frame_done;

  modport slave (
    input  value, load, enable,
    output AN, SEG, frame_done
  );

  modport master (
    output value, load, enable,
    input  AN, SEG, frame_done
  );

endinterface

// File: rtl/seg_scan_hex_to_seg.sv
// Hex nibble to active-low 7-segment cathode pattern.
// Purely combinational lookup into the shared table.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[hex_i];

endmodule

// File: rtl/seg_scan.sv
// 8-digit multiplexed hex display scanner.
// New words are only committed at frame boundaries.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned DIGIT_CYCLES = 100000,
  parameter bit          BLANK_LZ     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  seg_scan_if.slave  bus
);

  localparam int unsigned CW = $clog2(DIGIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT =
    CW'(DIGIT_CYCLES - 1);
  localparam idx_t LAST_IDX = idx_t'(DIGITS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  idx_t          idx_q, idx_d;
  logic [31:0]   shown_q, shown_d;
  logic [31:0]   pend_q, pend_d;
  logic          pflag_q, pflag_d;
  logic [7:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;

  logic          tick;
  logic          boundary;
  logic [31:0]   upper;
  logic          lz;
  logic [6:0]    seg7;

  // upper holds the current nibble and everything above it
  assign upper = shown_q >> {idx_q, 2'b00};

  hex_to_seg u_dec (
    .hex_i (upper[3:0]),
    .seg_o (seg7)
  );

  always_comb begin
    tick     = (cnt_q == LAST_CNT);
    boundary = tick && (idx_q == LAST_IDX);
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 1'b1 : idx_q;
    fd_d     = boundary;
    pend_d   = bus.load ? bus.value : pend_q;
    pflag_d  = pflag_q;
    shown_d  = shown_q;

    if (boundary) begin
      if (bus.load) begin
        shown_d = bus.value;
      end else if (pflag_q) begin
        shown_d = pend_q;
      end
      pflag_d = 1'b0;
    end else if (bus.load) begin
      pflag_d = 1'b1;
    end

    lz    = BLANK_LZ && (idx_q != '0) &&
            (upper == '0);
    an_d  = SEG_BLANK;
    seg_d = SEG_BLANK;
    if (bus.enable && !lz) begin
      an_d  = ~(8'd1 << idx_q);
      seg_d = {1'b1, seg7};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      shown_q <= '0;
      pend_q  <= '0;
      pflag_q <= 1'b0;
      an_q    <= SEG_BLANK;
      seg_q   <= SEG_BLANK;
      fd_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shown_q <= shown_d;
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEG        = seg_q;
  assign bus.frame_done = fd_q;

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter DIGIT_CYCLES, default 100000: clock cycles each digit is driven; legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1: 1 blanks leading zero digits; digit 0 is never blanked.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port value  input  32  hex word to display; nibble n drives digit n, digit 0 rightmost.
REQ-006 Port load  input  1  single-cycle strobe that captures value into the pending register.
REQ-007 Port enable  input  1  0 turns the display off; the scan continues internally.
REQ-008 Port AN  output  8  active-low anode selects; AN[n] selects digit n.
REQ-009 Port SEG  output  8  active-low cathodes: SEG[7] is dp, SEG[6:0] is g..a.
REQ-010 Port frame_done  output  1  one-cycle pulse at the end of each 8-digit scan.

Function
REQ-011 The prescaler counts 0..DIGIT_CYCLES-1 and wraps to 0; tick is asserted when the count equals DIGIT_CYCLES-1.
REQ-012 The digit index idx (3 bits) increments on tick and wraps from 7 to 0.
REQ-013 The boundary condition is tick && idx==7; frame_done is registered and is 1 in the cycle after each boundary.
REQ-014 Load handling: load sets pending<=value and pend_flag<=1; with several loads before a boundary, the last one wins.
REQ-015 At a boundary with no load, shown<=pending if pend_flag=1; pend_flag then clears.
REQ-016 At a boundary with load in the same cycle, shown<=value directly and pend_flag<=0, so there is no one-frame delay.
REQ-017 shown changes only at boundaries, so no frame ever mixes old and new digits.
REQ-018 AN and SEG are registered and reflect idx with a latency of 1 cycle.
REQ-019 When enabled, AN has exactly one 0 bit, at position idx; SEG = {1, hex_to_seg(shown nibble idx)}, so dp is always off.
REQ-020 Decode table (SEG hex): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
REQ-021 Leading-zero blanking: with BLANK_LZ=1 and idx>0, if nibble idx and all higher nibbles of shown are 0, then AN=FF and SEG=FF for that slot.
REQ-022 enable=0 forces AN=FF and SEG=FF from the next cycle; the prescaler, idx, frame_done and the load path are unaffected.
REQ-023 There is no other handshake: load is never back-pressured and the block has no busy output.

Reset
REQ-024 While rst=1: prescaler=0, idx=0, shown=0, pending=0, pend_flag=0, AN=FF, SEG=FF, frame_done=0.
REQ-025 rst takes priority over load and enable; any pending value is discarded, including on a reset mid-frame.
REQ-026 In the first cycle after rst falls with enable=1, AN=FE and SEG=C0.

Structure
REQ-027 Package seg_pkg holds DIGITS=8, the 16-entry active-low pattern table, and SEG_BLANK=8'hFF.
REQ-028 A sub-module hex_to_seg (4-bit in, 7-bit out, combinational) implements the table; all other logic stays in seg_scan.
REQ-029 The RTL is 120-400 lines; no clock gating or derived clocks are used, and tick is an enable only.

Verification (DIGIT_CYCLES=4, frame=32 cycles)
REQ-030 Reset, then enable=1 with value 0 and BLANK_LZ=1 -> AN=FE/SEG=C0 for 4 cycles, then AN=FF/SEG=FF for digits 1..7; frame_done every 32 cycles.
REQ-031 load 32'h1234ABCD mid-frame -> the current frame is unchanged; next frame gives digit0 SEG=A1, digit3 SEG=88, digit4 SEG=99, digit7 SEG=F9 with AN=7F.
REQ-032 load 32'h00000005 then 32'h00000007 in the same frame -> the next frame shows 7 (SEG=F8) on digit 0 and digits 1..7 blanked.
REQ-033 load 32'hFFFFFFFF in the boundary cycle -> the frame starting next shows all digits SEG=8E; the following frame is also unchanged.
REQ-034 enable=0 for 40 cycles -> AN=FF/SEG=FF from the next cycle; frame_done keeps a 32-cycle period; re-enabling resumes at the current idx.
REQ-035 Load 32'h88888888 pending, then rst pulse before the boundary -> after reset digit0 SEG=C0 and the 8s never appear.
